// File: rtl/aibnd_dcc_pkg.sv
// Shared types and helpers for the DCC delay-line calibration controller.
package aibnd_dcc_pkg;

  localparam int CODE_W_DEFAULT = 10;

  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    MEAS,
    WAIT,
    UPDATE,
    LOCKED
  } state_t;

  function automatic logic [31:0] bin2gray(input logic [31:0] bin);
    return bin ^ (bin >> 1);
  endfunction

endpackage

// File: rtl/aibnd_dcc_sync2.sv
// Two-flop synchronizer bringing the asynchronous phase-detector verdict into clk.
module aibnd_dcc_sync2 (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic [1:0] sync_q;
  logic [1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[0], d};
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q = sync_q[1];

endmodule

// File: rtl/aibnd_dcc_dll_ctrl.sv
// DCC delay-line calibration: launch/measure pulse pairs, sample the phase verdict,
// step a saturating delay code (Gray-coded out) until direction reversals declare lock.
module aibnd_dcc_dll_ctrl
  import aibnd_dcc_pkg::*;
#(
  parameter int CODE_W     = CODE_W_DEFAULT,
  parameter int CODE_INIT  = 64,
  parameter int SETTLE_CYC = 8,
  parameter int LOCK_FLIPS = 4,
  parameter int CNT_W      = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cal_en,
  input  logic              pd_early,
  output logic              launch,
  output logic              measure,
  output logic [CODE_W-1:0] gray,
  output logic              dll_lock_reg,
  output logic              cal_err
);

  localparam logic [CODE_W-1:0] CODE_RST  = CODE_W'(CODE_INIT);
  localparam logic [CODE_W-1:0] GRAY_RST  = CODE_W'(bin2gray(32'(CODE_INIT)));
  localparam logic [CODE_W-1:0] CODE_MAX  = '1;
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0]  FLIP_LOCK = CNT_W'(LOCK_FLIPS);

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [CNT_W-1:0]    flips_q, flips_d;
  logic [CODE_W-1:0]   code_q, code_d;
  logic [CODE_W-1:0]   gray_q, gray_d;
  logic                prev_dir_q, prev_dir_d;
  logic                first_q, first_d;
  logic                launch_q, launch_d;
  logic                measure_q, measure_d;
  logic                lock_q, lock_d;
  logic                cal_err_q, cal_err_d;
  logic                pd_sync;

  aibnd_dcc_sync2 u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (pd_early),
    .q       (pd_sync)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    flips_d    = flips_q;
    code_d     = code_q;
    prev_dir_d = prev_dir_q;
    first_d    = first_q;
    cal_err_d  = cal_err_q;

    case (state_q)
      IDLE: begin
        first_d = 1'b1;
        flips_d = '0;
        if (cal_en) state_d = LAUNCH;
      end
      LAUNCH: state_d = MEAS;
      MEAS: begin
        state_d = WAIT;
        cnt_d   = '0;
      end
      WAIT: begin
        if (cnt_q == CNT_LAST) state_d = UPDATE;
        else                   cnt_d   = cnt_q + 1'b1;
      end
      UPDATE: begin
        prev_dir_d = pd_sync;
        first_d    = 1'b0;
        if (first_q)                   flips_d = '0;
        else if (pd_sync != prev_dir_q) flips_d = flips_q + 1'b1;
        else                           flips_d = '0;

        if (flips_d == FLIP_LOCK) begin
          state_d = LOCKED;
        end else begin
          state_d = LAUNCH;
          // Saturating step; hitting either rail flags a calibration that cannot converge.
          if (pd_sync) begin
            if (code_q == CODE_MAX) cal_err_d = 1'b1;
            else                    code_d    = code_q + 1'b1;
          end else begin
            if (code_q == '0) cal_err_d = 1'b1;
            else              code_d    = code_q - 1'b1;
          end
        end
      end
      LOCKED: state_d = LOCKED;
      default: state_d = IDLE;
    endcase

    if (!cal_en) begin
      state_d = IDLE;
      flips_d = '0;
      first_d = 1'b1;
    end

    launch_d  = (state_d == LAUNCH);
    measure_d = (state_d == MEAS);
    lock_d    = (state_d == LOCKED);
    gray_d    = CODE_W'(bin2gray(32'(code_d)));
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      flips_q    <= '0;
      code_q     <= CODE_RST;
      gray_q     <= GRAY_RST;
      prev_dir_q <= 1'b0;
      first_q    <= 1'b1;
      launch_q   <= 1'b0;
      measure_q  <= 1'b0;
      lock_q     <= 1'b0;
      cal_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      flips_q    <= flips_d;
      code_q     <= code_d;
      gray_q     <= gray_d;
      prev_dir_q <= prev_dir_d;
      first_q    <= first_d;
      launch_q   <= launch_d;
      measure_q  <= measure_d;
      lock_q     <= lock_d;
      cal_err_q  <= cal_err_d;
    end
  end

  assign launch       = launch_q;
  assign measure      = measure_q;
  assign gray         = gray_q;
  assign dll_lock_reg = lock_q;
  assign cal_err      = cal_err_q;

endmodule

// File: tb/tb_aibnd_dcc_dll_ctrl.sv
// Bench for the DCC calibration controller: expected Gray codes and lock codes are queued by
// the stimulus thread and consumed by a monitor whenever the DUT changes gray or raises lock.
module tb_aibnd_dcc_dll_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_n, cal_en, pd_early, cal_en_s, pd_s;
  logic       launch, measure, dll_lock_reg, cal_err;
  logic [9:0] gray;
  logic       launch_s, measure_s, lock_s, cal_err_s;
  logic [9:0] gray_s;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int pulse_cnt = 0;
  int launch_s_cnt = 0;
  bit mon_en = 1'b0;
  logic pd_mode = 1'b0;
  logic pd_fixed = 1'b0;

  typedef struct packed {
    logic [9:0] g;
    logic       one_bit;
  } exp_t;

  exp_t       exp_gray_q[$];
  logic [9:0] exp_lock_q[$];

  function automatic logic [9:0] g2b(input logic [9:0] g);
    logic [9:0] b;
    b[9] = g[9];
    for (int i = 8; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  function automatic logic [9:0] b2g(input logic [9:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
               name, act, act, exp, exp, cyc);
    end
  endtask

  task automatic push_codes(input int from, input int to);
    exp_t e;
    if (from <= to) begin
      for (int c = from; c <= to; c++) begin
        e.g = b2g(10'(c)); e.one_bit = 1'b1; exp_gray_q.push_back(e);
      end
    end else begin
      for (int c = from; c >= to; c--) begin
        e.g = b2g(10'(c)); e.one_bit = 1'b1; exp_gray_q.push_back(e);
      end
    end
  endtask

  assign pd_early = pd_mode ? (g2b(gray) < 10'd100) : pd_fixed;

  aibnd_dcc_dll_ctrl #(
    .CODE_W(10), .CODE_INIT(64), .SETTLE_CYC(8), .LOCK_FLIPS(4), .CNT_W(4)
  ) dut (
    .clk(clk), .reset_n(reset_n), .cal_en(cal_en), .pd_early(pd_early),
    .launch(launch), .measure(measure), .gray(gray),
    .dll_lock_reg(dll_lock_reg), .cal_err(cal_err)
  );

  aibnd_dcc_dll_ctrl #(
    .CODE_W(10), .CODE_INIT(1023), .SETTLE_CYC(8), .LOCK_FLIPS(4), .CNT_W(4)
  ) dut_sat (
    .clk(clk), .reset_n(reset_n), .cal_en(cal_en_s), .pd_early(pd_s),
    .launch(launch_s), .measure(measure_s), .gray(gray_s),
    .dll_lock_reg(lock_s), .cal_err(cal_err_s)
  );

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor / scoreboard
  logic [9:0] prev_gray, prev_gray_s;
  logic       prev_launch = 1'b0, prev_measure = 1'b0, prev_lock = 1'b0;
  exp_t       mon_e;
  logic [9:0] mon_lc;

  always @(negedge clk) begin
    if (mon_en) begin
      if (gray !== prev_gray) begin
        if (exp_gray_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_gray: got 0x%0h expected no change from 0x%0h at cycle %0d",
                   gray, prev_gray, cyc);
        end else begin
          mon_e = exp_gray_q.pop_front();
          chk("gray_step", gray, mon_e.g);
          if (mon_e.one_bit) chk("gray_one_bit", $countones(gray ^ prev_gray), 1);
        end
      end
      if (gray_s !== prev_gray_s) begin
        checks++; errors++;
        $display("FAIL sat_gray_moved: got 0x%0h expected 0x%0h at cycle %0d",
                 gray_s, prev_gray_s, cyc);
      end
      if (launch || measure) begin
        pulse_cnt++;
        chk("pulse_proto", {29'd0, launch & measure, launch & prev_launch,
                            measure & prev_measure}, 0);
      end
      if (launch_s) launch_s_cnt++;
      if (dll_lock_reg && !prev_lock) begin
        if (exp_lock_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_lock: got lock=1 expected 0 at cycle %0d", cyc);
        end else begin
          mon_lc = exp_lock_q.pop_front();
          chk("lock_code", g2b(gray), mon_lc);
        end
      end
    end
    prev_gray    = gray;
    prev_gray_s  = gray_s;
    prev_launch  = launch;
    prev_measure = measure;
    prev_lock    = dll_lock_reg;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   t0, n0;
    bit   ok;
    exp_t er;
    reset_n = 1'b0; cal_en = 1'b0; cal_en_s = 1'b0; pd_s = 1'b1;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    mon_en  = 1'b1;

    // Reset state
    chk("rst_gray", gray, 10'h060);
    chk("rst_lock", dll_lock_reg, 0);
    chk("rst_cal_err", cal_err, 0);
    chk("rst_launch", launch, 0);
    chk("rst_measure", measure, 0);
    chk("rst_sat_gray", gray_s, 10'h200);
    n0 = pulse_cnt;
    repeat (20) @(negedge clk);
    chk("idle_no_pulses", pulse_cnt - n0, 0);

    // Climb with pd_early=1: pulse timing and gray stepping
    pd_fixed = 1'b1;
    push_codes(65, 68);
    t0 = cyc;
    cal_en = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (launch) begin ok = 1'b1; break; end
    end
    chk("first_launch_seen", ok, 1);
    chk("first_launch_latency", cyc - t0, 1);
    t0 = cyc;
    @(negedge clk);
    chk("measure_after_launch", measure, 1);
    chk("launch_dropped", launch, 0);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (launch) begin ok = 1'b1; break; end
    end
    chk("second_launch_seen", ok, 1);
    chk("loop_period", cyc - t0, 11);
    chk("gray_at_second_launch", gray, b2g(10'd65));

    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (exp_gray_q.size() == 0) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    chk("climb_done", ok, 1);

    // Drop cal_en mid-WAIT
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (measure) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    chk("measure_before_drop", ok, 1);
    repeat (2) @(negedge clk);
    cal_en = 1'b0;
    @(negedge clk);
    chk("drop_launch", launch, 0);
    chk("drop_measure", measure, 0);
    n0 = pulse_cnt;
    repeat (15) @(negedge clk);
    chk("drop_no_pulses", pulse_cnt - n0, 0);
    chk("drop_code_kept", g2b(gray), 68);

    // Re-enable downward from the retained code
    pd_fixed = 1'b0;
    push_codes(67, 66);
    cal_en = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (exp_gray_q.size() == 0) begin ok = 1'b1; break; end
    end
    chk("resume_done", ok, 1);
    cal_en = 1'b0;
    chk("resume_no_lock", dll_lock_reg, 0);
    repeat (4) @(negedge clk);

    // Dither around 99/100 until lock
    pd_mode = 1'b1;
    push_codes(67, 100);
    push_codes(99, 99);
    push_codes(100, 100);
    push_codes(99, 99);
    exp_lock_q.push_back(10'd99);
    cal_en = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 700; i++) begin
      @(negedge clk);
      if (dll_lock_reg) begin ok = 1'b1; break; end
    end
    chk("lock_reached", ok, 1);
    chk("lock_queue_drained", exp_gray_q.size(), 0);
    n0 = pulse_cnt;
    repeat (30) @(negedge clk);
    chk("locked_no_pulses", pulse_cnt - n0, 0);
    chk("locked_code", g2b(gray), 99);
    chk("locked_held", dll_lock_reg, 1);
    chk("locked_no_err", cal_err, 0);

    // Reset while locked
    er.g = 10'h060; er.one_bit = 1'b0;
    exp_gray_q.push_back(er);
    reset_n = 1'b0;
    cal_en  = 1'b0;
    @(negedge clk);
    chk("rlk_gray", gray, 10'h060);
    chk("rlk_lock", dll_lock_reg, 0);
    chk("rlk_cal_err", cal_err, 0);
    chk("rlk_launch", launch, 0);
    chk("rlk_measure", measure, 0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // Saturation at the top rail
    n0 = launch_s_cnt;
    cal_en_s = 1'b1;
    repeat (40) @(negedge clk);
    chk("sat_running", launch_s_cnt - n0 > 0, 1);
    chk("sat_cal_err", cal_err_s, 1);
    chk("sat_no_lock", lock_s, 0);
    chk("sat_gray", gray_s, 10'h200);
    cal_en_s = 1'b0;
    repeat (3) @(negedge clk);
    chk("sat_err_sticky", cal_err_s, 1);

    chk("final_queue_empty", exp_gray_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
